// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
//   Shared definitions for the parametrised one-hot decoder with auto-scan.
//   Build option: DEC_SCAN_EN (scan mode). It does not change this package.
//   Contents:
//     ST_IDLE / ST_HOLD / ST_SCAN  state encodings for the decoder FSM
//     ONEHOT_W                     widest one-hot vector the helpers produce
//     onehot(idx)                  one-hot vector with bit idx set
//     in_range(idx, num)           true when idx selects an existing line
// ----------------------------------------------------------------------------
package decoder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    // An 8-bit select reaches at most 256 lines. Callers cut the result down
    // to their own NUM_OUT width with a size cast.
    localparam int ONEHOT_W = 256;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [7:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic in_range(input logic [7:0] idx, input int num);
        return int'(idx) < num;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// ----------------------------------------------------------------------------
// dwell_counter
//   Times how long each scan step lasts. Each step lasts (dwell + 1) cycles.
//   The dwell value is latched on load. Later changes to dwell_i are ignored
//   until the next load.
//   Build option: DEC_SCAN_EN. The top level instantiates this module only
//   when that macro is defined.
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     load_i       latch dwell_i and start the first step
//     dwell_i      hold time per step, minus one
//     run_i        a scan is in progress; count down
//     step_done_o  high on the last cycle of the current step
// ----------------------------------------------------------------------------
module dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               run_i,
    output logic               step_done_o
);

    logic [DWELL_W-1:0] reload_q;
    logic [DWELL_W-1:0] reload_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // The counter runs from the latched dwell down to zero. Zero marks the
    // last cycle of a step. The next step reloads from the latched copy, not
    // from the live input.
    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            reload_d = dwell_i;
            cnt_d    = dwell_i;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
        end
    end

    assign step_done_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/param_decoder_scan.sv
// ----------------------------------------------------------------------------
// param_decoder_scan
//   Registered N-to-M one-hot decoder with a valid/ready select handshake and
//   an out-of-range error pulse. An optional auto-scan mode walks the one-hot
//   output across all lines. Each line is held for a programmable dwell.
//   Build option: DEC_SCAN_EN enables scan mode.
//     Without it, mode, scan_start and dwell are ignored, busy is 0 and
//     in_ready is always 1.
//   Ports:
//     clk, reset           rising-edge clock, synchronous active-high reset
//     in_valid/in_ready    select handshake; accept = in_valid & in_ready
//     in_sel               requested line index
//     mode                 0 = direct decode, 1 = scan
//     scan_start           start a scan (with mode = 1, no accept)
//     dwell                scan hold per line, minus one; latched at start
//     out                  registered one-hot (or all-zero) output
//     out_valid            out holds a decoded line
//     busy                 scan in progress
//     err                  one-cycle pulse after an out-of-range select
// ----------------------------------------------------------------------------
module param_decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               mode,
    input  logic               scan_start,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic               busy,
    output logic               err
);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [NUM_OUT-1:0] out_q;
    logic [NUM_OUT-1:0] out_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               err_q;
    logic               err_d;
    logic               accept;

`ifdef DEC_SCAN_EN
    logic [SEL_W-1:0]   idx_q;
    logic [SEL_W-1:0]   idx_d;
    logic               scan_load;
    logic               step_done;

    // Selects are refused only while the scan owns the output.
    assign in_ready = (state_q != ST_SCAN);
    assign busy     = (state_q == ST_SCAN);

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk         (clk),
        .reset       (reset),
        .load_i      (scan_load),
        .dwell_i     (dwell),
        .run_i       (busy),
        .step_done_o (step_done)
    );
`else
    logic scan_unused;

    assign in_ready    = 1'b1;
    assign busy        = 1'b0;
    assign scan_unused = ^{mode, scan_start, dwell};
`endif

    assign accept = in_valid && in_ready;

    // Next-state logic. An accepted select always wins over scan_start.
    // In scan, the index advances or the scan exits only on the last cycle
    // of a step. A mode drop in the middle of a step therefore finishes that
    // step first.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
`ifdef DEC_SCAN_EN
        idx_d       = idx_q;
        scan_load   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (in_range(8'(in_sel), NUM_OUT)) begin
                        out_d       = NUM_OUT'(onehot(8'(in_sel)));
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        err_d       = 1'b1;
                        state_d     = ST_IDLE;
                    end
`ifdef DEC_SCAN_EN
                end else if (mode && scan_start) begin
                    state_d     = ST_SCAN;
                    idx_d       = '0;
                    out_d       = NUM_OUT'(onehot(8'd0));
                    out_valid_d = 1'b1;
                    scan_load   = 1'b1;
`endif
                end
            end
`ifdef DEC_SCAN_EN
            ST_SCAN: begin
                if (step_done) begin
                    if (!mode) begin
                        state_d     = ST_IDLE;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        // Wrap at the last real line so unused codes are
                        // never driven.
                        if (idx_q == SEL_W'(NUM_OUT - 1)) begin
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                        out_d = NUM_OUT'(onehot(8'(idx_d)));
                    end
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Registers. Reset takes priority on the edge where it is asserted, even
    // in the middle of a scan or a decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef DEC_SCAN_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
`ifdef DEC_SCAN_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_param_decoder_scan.sv
// ----------------------------------------------------------------------------
// tb_param_decoder_scan
//   Self-checking bench for param_decoder_scan. It drives two instances from
//   the same inputs: an 8-line decoder and a 6-line decoder (SEL_W = 3). On
//   the 6-line decoder, selects 6 and 7 are out of range and its scan wraps
//   at line 5.
// ----------------------------------------------------------------------------
module tb_param_decoder_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic [2:0] inSel;
    logic       mode;
    logic       scanStart;
    logic [3:0] dwell;

    logic [7:0] out8;
    logic       outValid8, busy8, err8, ready8;
    logic [5:0] out6;
    logic       outValid6, busy6, err6, ready6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [2:0] sel;
        logic [7:0] exp8;
        logic       expValid8;
        logic [5:0] exp6;
        logic       expValid6;
        logic       expErr6;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    param_decoder_scan #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(ready8),
        .in_sel(inSel), .mode(mode), .scan_start(scanStart), .dwell(dwell),
        .out(out8), .out_valid(outValid8), .busy(busy8), .err(err8)
    );

    param_decoder_scan #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(4)) dut6 (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(ready6),
        .in_sel(inSel), .mode(mode), .scan_start(scanStart), .dwell(dwell),
        .out(out6), .out_valid(outValid6), .busy(busy6), .err(err6)
    );

    // Advance one cycle. Sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic m,
                                 input logic st, input logic [3:0] d);
        inValid   = v;
        inSel     = s;
        mode      = m;
        scanStart = st;
        dwell     = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        // Direct-decode vectors. Each row is applied for one cycle and checked
        // one cycle later.
        vecs[0]  = '{1'b1, 3'd0, 8'h01, 1'b1, 6'h01, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 8'h02, 1'b1, 6'h02, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 8'h04, 1'b1, 6'h04, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 8'h08, 1'b1, 6'h08, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd4, 8'h10, 1'b1, 6'h10, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'd5, 8'h20, 1'b1, 6'h20, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd6, 8'h40, 1'b1, 6'h00, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 3'd6, 8'h40, 1'b1, 6'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'd7, 8'h80, 1'b1, 6'h00, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'd7, 8'h80, 1'b1, 6'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'd7, 8'h80, 1'b1, 6'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 3'd2, 8'h04, 1'b1, 6'h04, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 3'd7, 8'h80, 1'b1, 6'h00, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 3'd7, 8'h80, 1'b1, 6'h00, 1'b0, 1'b0};

        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_out8", 32'(out8), 32'h0);
        checkOutput("reset_valid8", 32'(outValid8), 32'h0);
        checkOutput("reset_busy8", 32'(busy8), 32'h0);
        checkOutput("reset_err8", 32'(err8), 32'h0);
        checkOutput("reset_ready8", 32'(ready8), 32'h1);
        checkOutput("reset_out6", 32'(out6), 32'h0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sel, 1'b0, 1'b0, 4'd0);
            tick();
            checkOutput($sformatf("vec%0d_out8", i), 32'(out8), 32'(vecs[i].exp8));
            checkOutput($sformatf("vec%0d_valid8", i), 32'(outValid8), 32'(vecs[i].expValid8));
            checkOutput($sformatf("vec%0d_err8", i), 32'(err8), 32'h0);
            checkOutput($sformatf("vec%0d_out6", i), 32'(out6), 32'(vecs[i].exp6));
            checkOutput($sformatf("vec%0d_valid6", i), 32'(outValid6), 32'(vecs[i].expValid6));
            checkOutput($sformatf("vec%0d_err6", i), 32'(err6), 32'(vecs[i].expErr6));
            checkOutput($sformatf("vec%0d_ready8", i), 32'(ready8), 32'h1);
        end

`ifdef DEC_SCAN_EN
        // Start a scan with dwell = 2. Then change dwell to 0 and hold a
        // select request; the scan must ignore both.
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 4'd2);
        tick();
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 4'd0);
        for (int step = 0; step < 10; step++) begin
            for (int c = 0; c < 3; c++) begin
                checkOutput($sformatf("scan_s%0d_c%0d_out8", step, c), 32'(out8), 32'h1 << (step % 8));
                checkOutput($sformatf("scan_s%0d_c%0d_out6", step, c), 32'(out6), 32'h1 << (step % 6));
                checkOutput($sformatf("scan_s%0d_c%0d_busy8", step, c), 32'(busy8), 32'h1);
                checkOutput($sformatf("scan_s%0d_c%0d_ready8", step, c), 32'(ready8), 32'h0);
                checkOutput($sformatf("scan_s%0d_c%0d_err6", step, c), 32'(err6), 32'h0);
                tick();
            end
        end

        // Now on cycle 0 of step 10 (line 2 on dut8, line 4 on dut6). Drop
        // mode in the middle of the step.
        checkOutput("drop_c0_out8", 32'(out8), 32'h04);
        mode = 1'b0;
        tick();
        checkOutput("drop_c1_out8", 32'(out8), 32'h04);
        checkOutput("drop_c1_busy8", 32'(busy8), 32'h1);
        tick();
        checkOutput("drop_c2_out8", 32'(out8), 32'h04);
        checkOutput("drop_c2_out6", 32'(out6), 32'h10);
        tick();
        checkOutput("drop_exit_out8", 32'(out8), 32'h0);
        checkOutput("drop_exit_valid8", 32'(outValid8), 32'h0);
        checkOutput("drop_exit_busy8", 32'(busy8), 32'h0);
        checkOutput("drop_exit_ready8", 32'(ready8), 32'h1);
        checkOutput("drop_exit_out6", 32'(out6), 32'h0);
        tick();
        checkOutput("held_req_out8", 32'(out8), 32'h20);
        checkOutput("held_req_out6", 32'(out6), 32'h20);

        // Reset asserted while the scan is on line 4.
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 4'd0);
        tick();
        scanStart = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checkOutput("rst_scan_pre_out8", 32'(out8), 32'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mode  = 1'b0;
        checkOutput("rst_scan_out8", 32'(out8), 32'h0);
        checkOutput("rst_scan_valid8", 32'(outValid8), 32'h0);
        checkOutput("rst_scan_busy8", 32'(busy8), 32'h0);
        checkOutput("rst_scan_ready8", 32'(ready8), 32'h1);
        checkOutput("rst_scan_out6", 32'(out6), 32'h0);

        // An accept in the same cycle as scan_start wins.
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("accept_wins_out8", 32'(out8), 32'h08);
        checkOutput("accept_wins_busy8", 32'(busy8), 32'h0);
        inValid = 1'b0;
        tick();
        checkOutput("late_start_out8", 32'(out8), 32'h01);
        checkOutput("late_start_busy8", 32'(busy8), 32'h1);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("dwell0_exit_out8", 32'(out8), 32'h0);
        checkOutput("dwell0_exit_busy8", 32'(busy8), 32'h0);
`else
        // Without scan support, mode and scan_start must have no effect.
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 4'd2);
        tick();
        checkOutput("noscan_hold_out8", 32'(out8), 32'h80);
        checkOutput("noscan_busy8", 32'(busy8), 32'h0);
        checkOutput("noscan_ready8", 32'(ready8), 32'h1);
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b1, 4'd2);
        tick();
        checkOutput("noscan_dec_out8", 32'(out8), 32'h10);
        checkOutput("noscan_dec_out6", 32'(out6), 32'h10);
        checkOutput("noscan_dec_busy6", 32'(busy6), 32'h0);
        inValid = 1'b0;
        tick();
        checkOutput("noscan_keep_out8", 32'(out8), 32'h10);
        checkOutput("noscan_keep_busy8", 32'(busy8), 32'h0);
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inValid = 1'b0;
        checkOutput("noscan_rst_out8", 32'(out8), 32'h0);
        checkOutput("noscan_rst_valid8", 32'(outValid8), 32'h0);
        checkOutput("noscan_rst_ready6", 32'(ready6), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
